// File: rtl/mode_buffer_pkg.sv
// mode_buffer_pkg: shared constants and helpers for mode_buffer.
//   MODE_PIPE / MODE_SKID / MODE_FIFO select the storage organisation;
//   any other MODE value builds the zero-storage bypass.
//   entries() maps (mode, depth) to the number of storage entries.
package mode_buffer_pkg;

  localparam int MODE_PIPE = 32'd1;
  localparam int MODE_SKID = 32'd2;
  localparam int MODE_FIFO = 32'd3;

  function automatic int entries(input int mode, input int depth);
    int n;
    case (mode)
      MODE_PIPE: n = 32'd1;
      MODE_SKID: n = 32'd2;
      MODE_FIFO: n = depth;
      default:   n = 32'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mode_buffer_fifo.sv
// mode_buffer_fifo: DEPTH-entry circular buffer with valid/ready on both sides.
//   Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data (producer),
//   out_valid/out_ready/out_data (consumer), count (occupancy, 32 bits).
//   Latency 1, no empty bypass. DEPTH must be a power of two >= 2.
module mode_buffer_fifo
  import mode_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mode_buffer_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  // live_q holds in_ready low until the first edge after reset release
  logic             live_q;
  logic             push_s, pop_s;

  assign in_ready  = live_q & (count_q != FULL);
  assign out_valid = (count_q != {CW{1'b0}});
  assign out_data  = out_valid ? mem_q[rptr_q] : {WIDTH{1'b0}};
  assign count     = {{(32-CW){1'b0}}, count_q};
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Next pointer and occupancy values
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      live_q  <= 1'b1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/mode_buffer.sv
// mode_buffer: valid/ready buffer whose storage organisation is chosen by MODE.
//   MODE 1 pipe (1 entry), 2 skid (2 entries), 3 fifo (DEPTH entries),
//   anything else bypass (0 entries, combinational).
//   Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, count (occupancy), capacity (storage bits,
//   constant), hwm (occupancy high-water mark).
//   Optional macro MODE_BUFFER_STATS_EN: makes hwm a real register;
//   otherwise hwm is tied to zero.
module mode_buffer
  import mode_buffer_pkg::*;
#(
  parameter int MODE  = 0,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      count,
  output logic [31:0]      capacity,
  output logic [31:0]      hwm
);

  localparam int          ENTRIES  = entries(MODE, DEPTH);
  localparam logic [31:0] CAPACITY = 32'(ENTRIES * WIDTH);

  assign capacity = CAPACITY;

  if (MODE == MODE_PIPE) begin : blk_pipe
    logic             live_q;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push_s, pop_s;

    assign in_ready  = live_q & (~valid_q | out_ready);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = valid_q & out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign count     = {31'd0, valid_q};

    // Single-register next state: a push always overwrites (slot is free or popping)
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (push_s) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (pop_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    // Pipe register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        live_q  <= 1'b0;
        valid_q <= 1'b0;
        data_q  <= {WIDTH{1'b0}};
      end else begin
        live_q  <= 1'b1;
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end else if (MODE == MODE_SKID) begin : blk_skid
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             rdy_q, rdy_d;
    logic             push_s, pop_s;

    // rdy_q mirrors !skid_valid_q, so a push never arrives while the skid is full
    assign in_ready  = rdy_q;
    assign push_s    = in_valid & rdy_q;
    assign pop_s     = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign count     = 32'(main_valid_q) + 32'(skid_valid_q);

    // Main/skid steering
    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
        if (pop_s) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end else if (push_s) begin
        if (!main_valid_q || pop_s) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end else if (pop_s) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
      rdy_d = ~skid_valid_d;
    end

    // Main, skid and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid_q <= 1'b0;
        main_data_q  <= {WIDTH{1'b0}};
        skid_valid_q <= 1'b0;
        skid_data_q  <= {WIDTH{1'b0}};
        rdy_q        <= 1'b0;
      end else begin
        main_valid_q <= main_valid_d;
        main_data_q  <= main_data_d;
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
        rdy_q        <= rdy_d;
      end
    end
  end else if (MODE == MODE_FIFO) begin : blk_fifo
    mode_buffer_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
    );
  end else begin : blk_bypass
    // Clock and reset have no role in the pass-through path
    logic bypass_unused_s;
    assign bypass_unused_s = clk ^ rst_n;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign count     = 32'd0;
  end

`ifdef MODE_BUFFER_STATS_EN
  logic [31:0] hwm_q, hwm_d;

  // High-water mark only ever grows, bounded by the entry count
  always_comb begin
    hwm_d = hwm_q;
    if ((count > hwm_q) && (count <= 32'(ENTRIES))) begin
      hwm_d = count;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // High-water mark register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= 32'd0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = 32'd0;
`endif

endmodule

// File: tb/tb_mode_buffer.sv
module tb_mode_buffer;

`ifdef MODE_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic f_rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;

  // pipe, WIDTH 8
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0]  p_in_data, p_out_data;
  logic [31:0] p_count, p_cap, p_hwm;
  // skid, WIDTH 16
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_in_data, s_out_data;
  logic [31:0] s_count, s_cap, s_hwm;
  // fifo, WIDTH 8, DEPTH 4
  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [7:0]  f_in_data, f_out_data;
  logic [31:0] f_count, f_cap, f_hwm;
  // bypass, WIDTH 4
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0]  b_in_data, b_out_data;
  logic [31:0] b_count, b_cap, b_hwm;

  mode_buffer #(.MODE(1), .WIDTH(8), .DEPTH(8)) u_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .count(p_count), .capacity(p_cap), .hwm(p_hwm));

  mode_buffer #(.MODE(2), .WIDTH(16), .DEPTH(8)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .count(s_count), .capacity(s_cap), .hwm(s_hwm));

  mode_buffer #(.MODE(3), .WIDTH(8), .DEPTH(4)) u_fifo (
    .clk(clk), .rst_n(f_rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_data(f_in_data), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_data(f_out_data), .count(f_count), .capacity(f_cap), .hwm(f_hwm));

  mode_buffer #(.MODE(7), .WIDTH(4), .DEPTH(8)) u_byp (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count), .capacity(b_cap), .hwm(b_hwm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop side compared first, since every stored mode has latency >= 1
  logic [7:0]  q_p[$];
  int          q_pc[$];
  logic [15:0] q_s[$];
  logic [7:0]  q_f[$];
  bit          p_stall, s_stall, f_stall;
  logic [7:0]  p_hold, f_hold;
  logic [15:0] s_hold;

  always @(negedge clk) begin
    logic [7:0] ed;
    int         pc;
    if (rst_n) begin
      if (p_stall) begin
        chk("pipe_hold_valid", 64'(p_out_valid), 64'd1);
        chk("pipe_hold_data", 64'(p_out_data), 64'(p_hold));
      end
      if (p_out_valid && p_out_ready) begin
        if (q_p.size() == 0) begin
          chk("pipe_unexpected_pop", 64'(q_p.size()), 64'd1);
        end else begin
          ed = q_p.pop_front();
          pc = q_pc.pop_front();
          chk("pipe_data", 64'(p_out_data), 64'(ed));
          if (lat_chk) chk("pipe_latency", 64'(cyc), 64'(pc + 1));
        end
      end
      if (p_in_valid && p_in_ready) begin
        q_p.push_back(p_in_data);
        q_pc.push_back(cyc);
      end
      p_stall = p_out_valid & ~p_out_ready;
      p_hold  = p_out_data;
    end else begin
      p_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [15:0] ed;
    if (rst_n) begin
      if (s_stall) begin
        chk("skid_hold_valid", 64'(s_out_valid), 64'd1);
        chk("skid_hold_data", 64'(s_out_data), 64'(s_hold));
      end
      if (s_out_valid && s_out_ready) begin
        if (q_s.size() == 0) begin
          chk("skid_unexpected_pop", 64'(q_s.size()), 64'd1);
        end else begin
          ed = q_s.pop_front();
          chk("skid_data", 64'(s_out_data), 64'(ed));
        end
      end
      if (s_in_valid && s_in_ready) q_s.push_back(s_in_data);
      s_stall = s_out_valid & ~s_out_ready;
      s_hold  = s_out_data;
    end else begin
      s_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed;
    if (f_rst_n) begin
      if (f_stall) begin
        chk("fifo_hold_valid", 64'(f_out_valid), 64'd1);
        chk("fifo_hold_data", 64'(f_out_data), 64'(f_hold));
      end
      if (f_out_valid && f_out_ready) begin
        if (q_f.size() == 0) begin
          chk("fifo_unexpected_pop", 64'(q_f.size()), 64'd1);
        end else begin
          ed = q_f.pop_front();
          chk("fifo_data", 64'(f_out_data), 64'(ed));
        end
      end
      if (f_in_valid && f_in_ready) q_f.push_back(f_in_data);
      f_stall = f_out_valid & ~f_out_ready;
      f_hold  = f_out_data;
    end else begin
      f_stall = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; f_rst_n = 1'b0;
    p_in_valid = 1'b0; p_in_data = 8'h00;  p_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = 16'h0;  s_out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_data = 8'h00;  f_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 4'h9;   b_out_ready = 1'b1;
    #12;
    // reset state
    chk("pipe_rst_valid", 64'(p_out_valid), 64'd0);
    chk("pipe_rst_data", 64'(p_out_data), 64'd0);
    chk("pipe_rst_ready", 64'(p_in_ready), 64'd0);
    chk("pipe_rst_count", 64'(p_count), 64'd0);
    chk("skid_rst_valid", 64'(s_out_valid), 64'd0);
    chk("skid_rst_ready", 64'(s_in_ready), 64'd0);
    chk("skid_rst_data", 64'(s_out_data), 64'd0);
    chk("fifo_rst_valid", 64'(f_out_valid), 64'd0);
    chk("fifo_rst_ready", 64'(f_in_ready), 64'd0);
    chk("fifo_rst_count", 64'(f_count), 64'd0);
    chk("fifo_rst_data", 64'(f_out_data), 64'd0);
    chk("pipe_capacity", 64'(p_cap), 64'd8);
    chk("skid_capacity", 64'(s_cap), 64'd32);
    chk("fifo_capacity_rst", 64'(f_cap), 64'd32);
    chk("byp_capacity", 64'(b_cap), 64'd0);
    chk("byp_in_reset_valid", 64'(b_out_valid), 64'd1);
    chk("byp_in_reset_data", 64'(b_out_data), 64'h9);
    rst_n = 1'b1; f_rst_n = 1'b1;
    tick();
    chk("pipe_ready_after_rst", 64'(p_in_ready), 64'd1);
    chk("skid_ready_after_rst", 64'(s_in_ready), 64'd1);
    chk("fifo_ready_after_rst", 64'(f_in_ready), 64'd1);

    // bypass: combinational pass-through
    b_in_valid = 1'b1; b_in_data = 4'hA; b_out_ready = 1'b0; #1;
    chk("byp_valid", 64'(b_out_valid), 64'd1);
    chk("byp_data_a", 64'(b_out_data), 64'hA);
    chk("byp_ready_lo", 64'(b_in_ready), 64'd0);
    b_in_data = 4'h5; b_out_ready = 1'b1; #1;
    chk("byp_data_5", 64'(b_out_data), 64'h5);
    chk("byp_ready_hi", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b0; #1;
    chk("byp_valid_lo", 64'(b_out_valid), 64'd0);
    chk("byp_count", 64'(b_count), 64'd0);
    chk("byp_hwm", 64'(b_hwm), 64'd0);

    // pipe: stream 0x01..0x10 with out_ready held high
    tick();
    lat_chk = 1'b1;
    p_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      p_in_valid = 1'b1; p_in_data = 8'(i);
      tick();
      chk("pipe_count_le1", 64'(p_count <= 32'd1), 64'd1);
      chk("pipe_stream_ready", 64'(p_in_ready), 64'd1);
    end
    p_in_valid = 1'b0;
    tick(); tick();
    lat_chk = 1'b0;
    chk("pipe_drained", 64'(q_p.size()), 64'd0);
    chk("pipe_hwm", 64'(p_hwm), STATS ? 64'd1 : 64'd0);

    // skid: fill main then skid with consumer stalled
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 16'hAAAA;
    tick();
    chk("skid_ready_one", 64'(s_in_ready), 64'd1);
    s_in_data = 16'hBBBB;
    tick();
    s_in_valid = 1'b0;
    chk("skid_ready_full", 64'(s_in_ready), 64'd0);
    chk("skid_count_full", 64'(s_count), 64'd2);
    s_out_ready = 1'b1; #1;
    chk("skid_ready_no_comb", 64'(s_in_ready), 64'd0);
    tick();
    chk("skid_ready_drained", 64'(s_in_ready), 64'd1);
    chk("skid_count_one", 64'(s_count), 64'd1);
    tick();
    s_out_ready = 1'b0;
    chk("skid_count_empty", 64'(s_count), 64'd0);
    chk("skid_valid_empty", 64'(s_out_valid), 64'd0);
    chk("skid_hwm", 64'(s_hwm), STATS ? 64'd2 : 64'd0);

    // fifo: overfill by one with consumer stalled
    f_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f_in_valid = 1'b1; f_in_data = 8'(8'h10 + i);
      tick();
    end
    chk("fifo_full_count", 64'(f_count), 64'd4);
    chk("fifo_full_ready", 64'(f_in_ready), 64'd0);
    chk("fifo_full_head", 64'(f_out_data), 64'h10);
    chk("fifo_capacity", 64'(f_cap), 64'd32);
    chk("fifo_hwm_full", 64'(f_hwm), STATS ? 64'd4 : 64'd0);
    f_out_ready = 1'b1;
    tick();
    f_out_ready = 1'b0;
    chk("fifo_after_pop_count", 64'(f_count), 64'd3);
    chk("fifo_after_pop_ready", 64'(f_in_ready), 64'd1);
    tick();
    f_in_valid = 1'b0;
    chk("fifo_refill_count", 64'(f_count), 64'd4);
    f_out_ready = 1'b1;
    repeat (5) tick();
    f_out_ready = 1'b0;
    chk("fifo_wrap_drained", 64'(q_f.size()), 64'd0);
    chk("fifo_empty_count", 64'(f_count), 64'd0);

    // fifo: steady push+pop at occupancy 2
    f_in_valid = 1'b1; f_in_data = 8'h20; tick();
    f_in_data = 8'h21; tick();
    f_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      f_in_data = 8'(8'h30 + i);
      tick();
      chk("fifo_steady_count", 64'(f_count), 64'd2);
    end
    f_in_valid = 1'b0;
    repeat (3) tick();
    f_out_ready = 1'b0;
    chk("fifo_steady_drained", 64'(q_f.size()), 64'd0);

    // random traffic on all stored modes
    for (int i = 0; i < 80; i++) begin
      p_in_valid = 1'($urandom_range(0, 1)); p_in_data = 8'($urandom);
      p_out_ready = 1'($urandom_range(0, 1));
      s_in_valid = 1'($urandom_range(0, 1)); s_in_data = 16'($urandom);
      s_out_ready = 1'($urandom_range(0, 1));
      f_in_valid = 1'($urandom_range(0, 1)); f_in_data = 8'($urandom);
      f_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chk("skid_count_bound", 64'(s_count <= 32'd2), 64'd1);
      chk("fifo_count_bound", 64'(f_count <= 32'd4), 64'd1);
    end
    p_in_valid = 1'b0; s_in_valid = 1'b0; f_in_valid = 1'b0;
    p_out_ready = 1'b1; s_out_ready = 1'b1; f_out_ready = 1'b1;
    repeat (6) tick();
    chk("pipe_rand_drained", 64'(q_p.size()), 64'd0);
    chk("skid_rand_drained", 64'(q_s.size()), 64'd0);
    chk("fifo_rand_drained", 64'(q_f.size()), 64'd0);
    chk("skid_rand_count", 64'(s_count), 64'd0);

    // fifo: asynchronous reset at occupancy 3
    f_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_in_valid = 1'b1; f_in_data = 8'(8'h40 + i);
      tick();
    end
    f_in_valid = 1'b0;
    chk("fifo_pre_rst_count", 64'(f_count), 64'd3);
    #3;
    f_rst_n = 1'b0;
    q_f.delete();
    #1;
    chk("fifo_async_valid", 64'(f_out_valid), 64'd0);
    chk("fifo_async_count", 64'(f_count), 64'd0);
    chk("fifo_async_ready", 64'(f_in_ready), 64'd0);
    chk("fifo_async_hwm", 64'(f_hwm), 64'd0);
    #2;
    f_rst_n = 1'b1;
    tick();
    chk("fifo_rerst_ready", 64'(f_in_ready), 64'd1);
    f_in_valid = 1'b1; f_in_data = 8'h55; tick();
    f_in_valid = 1'b0;
    chk("fifo_hwm_after_push", 64'(f_hwm), STATS ? 64'd1 : 64'd0);
    chk("fifo_head_55", 64'(f_out_data), 64'h55);
    f_in_valid = 1'b1; f_in_data = 8'h56; tick();
    f_in_valid = 1'b0;
    f_out_ready = 1'b1;
    repeat (3) tick();
    chk("fifo_rst_drained", 64'(q_f.size()), 64'd0);
    chk("fifo_final_count", 64'(f_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
